// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and its width.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between upstream logic (master) and the serial adder (slave).
// The sub request bit exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a_in, b_in, cin, sub,
    input  busy, done, sum_out, cout, overflow
  );

  modport slave (
    input  start, a_in, b_in, cin, sub,
    output busy, done, sum_out, cout, overflow
  );
`else
  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout, overflow
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout, overflow
  );
`endif

endinterface

// File: rtl/serial_adder_ctrl_full_add_cell.sv
// Single-bit full adder reused every cycle by the serial adder sequencer.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder cell, LSB first, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to enable subtract mode (bus.sub selects A-B).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cell_s;
  logic             cell_c;

  full_add_cell u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_c)
  );

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a_in;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction is A + ~B + 1; cout then reads as "no borrow".
          b_sh_d  = bus.sub ? ~bus.b_in : bus.b_in;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_sh_d  = bus.b_in;
          carry_d = bus.cin;
`endif
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        carry_d = cell_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Carry entering the MSB cell, kept for the signed-overflow check.
          cmsb_d  = carry_q;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      DONE: begin
        sum_d   = res_q;
        cout_d  = carry_q;
        ovf_d   = cmsb_q ^ carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum_out  = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors plus randomized operations
// checked against an arithmetic reference model (define SERIAL_ADDER_SUB_EN for subtract tests).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference result {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic sb);
    longint ua, ub, sa, sbv, u, si, lim;
    logic [W-1:0] s;
    logic co, ov;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (sb) begin
      u  = ua - ub;
      co = (ua >= ub);
      si = sa - sbv;
    end else begin
      u  = ua + ub + longint'(ci);
      co = (u >= (longint'(1) << W));
      si = sa + sbv + longint'(ci);
    end
    s  = u[W-1:0];
    ov = (si > lim - 1) || (si < -lim);
    return {ov, co, s};
  endfunction

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb);
    bus.a_in = a;
    bus.b_in = b;
    bus.cin  = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub  = sb;
`else
    if (sb) bus.cin = ci;
`endif
  endtask

  // One operation: start pulse, scramble operands during RUN, watch W+6 edges.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb, output logic [W+1:0] res, output int lat,
                       output int ndone, output logic busy0, output logic [W-1:0] sum0);
    @(negedge clk);
    set_ops(a, b, ci, sb);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    busy0 = bus.busy;
    sum0  = bus.sum_out;
    @(negedge clk);
    bus.start = 1'b0;
    set_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    lat   = -1;
    ndone = 0;
    for (int k = 1; k <= W + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    res = {bus.overflow, bus.cout, bus.sum_out};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_ops({W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy,done got %b want 00", {bus.busy, bus.done});
    end
    n_tests++;
    if ({bus.overflow, bus.cout, bus.sum_out} !== {(W+2){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", {bus.overflow, bus.cout, bus.sum_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] av[3]    = '{8'h35, 8'hFF, 8'h7F};
    logic [W-1:0] bv[3]    = '{8'h4A, 8'h00, 8'h01};
    logic         cv[3]    = '{1'b0, 1'b1, 1'b0};
    logic [W+1:0] expv[3]  = '{{1'b0, 1'b0, 8'h7F}, {1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}};
    logic [W+1:0] res;
    logic [W-1:0] sum0;
    logic [W-1:0] prev_sum;
    logic         busy0;
    int           lat, nd;
    prev_sum = {W{1'b0}};
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], cv[i], 1'b0, res, lat, nd, busy0, sum0);
      n_tests++;
      if (res !== expv[i]) begin
        n_fail++;
        $display("FAIL basic_result[%0d]: {ovf,cout,sum} got %h want %h", i, res, expv[i]);
      end
      n_tests++;
      if (lat != W + 1 || nd != 1) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: done at edge %0d x%0d, want edge %0d x1", i, lat, nd, W + 1);
      end
      n_tests++;
      if (busy0 !== 1'b1 || sum0 !== prev_sum) begin
        n_fail++;
        $display("FAIL basic_accept[%0d]: busy %b sum_out %h, want busy 1 sum_out %h", i, busy0, sum0, prev_sum);
      end
      prev_sum = expv[i][W-1:0];
    end
  endtask

  task automatic test_reset_mid_run();
    int nd = 0;
    @(negedge clk);
    set_ops(8'hFF, 8'h01, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.cout, bus.sum_out} !== {3'b000, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy %b done %b cout %b sum %h, want all 0", bus.busy, bus.done, bus.cout, bus.sum_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) nd++;
    end
    n_tests++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity on %0d cycles after release, want 0", nd);
    end
  endtask

  task automatic test_busy_ignore();
    int           nd  = 0;
    int           lat = -1;
    logic [W+1:0] res = {(W+2){1'b0}};
    @(negedge clk);
    set_ops(8'h12, 8'h34, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= W + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        if (lat < 0) begin
          lat = k;
          res = {bus.overflow, bus.cout, bus.sum_out};
        end
      end
      @(negedge clk);
      bus.start = (k == 3);
      if (k == 3) set_ops(8'h01, 8'h01, 1'b0, 1'b0);
    end
    n_tests++;
    if (nd != 1 || lat != W + 1) begin
      n_fail++;
      $display("FAIL busy_ignore_done: %0d pulses first at %0d, want 1 at %0d", nd, lat, W + 1);
    end
    n_tests++;
    if (res !== {2'b00, 8'h46} || bus.sum_out !== 8'h46) begin
      n_fail++;
      $display("FAIL busy_ignore_result: got %h (now %h) want 046", res, bus.sum_out);
    end
  endtask

  task automatic test_back_to_back();
    localparam int NOPS = 4;
    logic [W+1:0] exp_q[$];
    logic [W-1:0] a, b;
    logic         ci;
    int           nd = 0, last = -1;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    @(negedge clk);
    set_ops(a, b, ci, 1'b0);
    exp_q.push_back(ref_op(a, b, ci, 1'b0));
    bus.start = 1'b1;
    for (int k = 0; k < NOPS * (W + 2) + 4 && nd < NOPS; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        n_tests++;
        if ({bus.overflow, bus.cout, bus.sum_out} !== exp_q[0] || (last >= 0 && k - last != W + 2)) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got %h at edge %0d (prev %0d) want %h spaced %0d",
                   nd, {bus.overflow, bus.cout, bus.sum_out}, k, last, exp_q[0], W + 2);
        end
        void'(exp_q.pop_front());
        last = k;
        @(negedge clk);
        if (nd < NOPS) begin
          a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
          set_ops(a, b, ci, 1'b0);
          exp_q.push_back(ref_op(a, b, ci, 1'b0));
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (nd != NOPS) begin
      n_fail++;
      $display("FAIL back_to_back_count: %0d results, want %0d", nd, NOPS);
    end
    apply_reset();
  endtask

  task automatic test_random(input int n, input logic use_sub);
    logic [W+1:0] res, expv;
    logic [W-1:0] a, b, sum0;
    logic         ci, sb, busy0;
    int           lat, nd;
    for (int i = 0; i < n; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      sb = use_sub & 1'($urandom);
      if (i == 0) begin a = {W{1'b0}}; b = {W{1'b0}}; end
      if (i == 1) begin a = {W{1'b1}}; b = {W{1'b1}}; end
      expv = ref_op(a, b, ci, sb);
      do_op(a, b, ci, sb, res, lat, nd, busy0, sum0);
      n_tests++;
      if (res !== expv || nd != 1 || lat != W + 1) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: got %h (done %0d@%0d) want %h",
                 i, a, b, ci, sb, res, nd, lat, expv);
      end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W+1:0] res;
    logic [W-1:0] sum0;
    logic         busy0;
    int           lat, nd;
    do_op(8'h10, 8'h20, 1'b0, 1'b1, res, lat, nd, busy0, sum0);
    n_tests++;
    if (res !== {2'b00, 8'hF0} || nd != 1) begin
      n_fail++;
      $display("FAIL sub_directed: got %h x%0d want 0F0 x1", res, nd);
    end
    do_op(8'h80, 8'h01, 1'b0, 1'b1, res, lat, nd, busy0, sum0);
    n_tests++;
    if (res !== {2'b11, 8'h7F}) begin
      n_fail++;
      $display("FAIL sub_overflow: got %h want 37F", res);
    end
    test_random(16, 1'b1);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    set_ops({W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_busy_ignore();
    test_back_to_back();
    test_random(24, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
